sha256_msg_schedule: RTL and testbench

SHA-256 message-schedule expander. Accepts one 512-bit padded block, then streams W[0]..W[63] one word per handshake to the compression round.
Internally computes the small sigma0 and sigma1 functions:
- sigma0 = rotr7 ^ rotr18 ^ shr3
- sigma1 = rotr17 ^ rotr19 ^ shr10

It sits directly downstream of the block padder and directly upstream of the round/compression stage.

---
 rtl/sha256_msg_schedule.sv | 138 +++++++++++++
 tb/tb_sha256_msg_schedule.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_schedule.sv
// -----------------------------------------------------------------------------
// sha256_msg_schedule
//
// SHA-256 message-schedule expander. Accepts one 512-bit padded block and
// streams W[0]..W[63] to the compression round, one word per handshake.
// A 16-word sliding window holds the most recent schedule words; the oldest
// word (win[0]) is always the word on offer, and each accepted word shifts
// the window down by one while the next word is computed into win[15].
//
// Ports:
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   blk_valid  padded block presented on blk_data
//   blk_ready  block accepted on blk_valid && blk_ready (high only in IDLE)
//   blk_data   512-bit block; word 0 = [511:480], word 15 = [31:0]
//   w_valid    w_data / w_idx valid (high in RUN)
//   w_ready    consumer accepts the word on w_valid && w_ready
//   w_data     schedule word W[w_idx]
//   w_idx      index of the word on offer, 0..63
//   busy       high in RUN
//   abort      (only with SHA256_SCHED_ABORT_EN) abandon the current block
//
// Optional feature macro: SHA256_SCHED_ABORT_EN adds the abort input.
// -----------------------------------------------------------------------------
module sha256_msg_schedule #(
    parameter int WORDS = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
`ifdef SHA256_SCHED_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy
);

    localparam logic [5:0] LAST_IDX = 6'(WORDS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  idx_reg, idx_next;
    logic [31:0] win_reg  [16];
    logic [31:0] win_next [16];
    logic [31:0] win_shift[16];
    logic [31:0] blk_word [16];
    logic [31:0] new_word;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // Next schedule word; computed every accepted cycle, even past W[63],
    // since those surplus words are simply never emitted.
    assign new_word = sigma1(win_reg[14]) + win_reg[9] + sigma0(win_reg[1]) + win_reg[0];

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_win
            assign blk_word[gi] = blk_data[511 - 32*gi -: 32];
            if (gi < 15) begin : g_mid
                assign win_shift[gi] = win_reg[gi + 1];
            end else begin : g_top
                assign win_shift[gi] = new_word;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        win_next   = win_reg;
        case (state_reg)
            IDLE: begin
                if (blk_valid) begin
                    state_next = RUN;
                    idx_next   = '0;
                    win_next   = blk_word;
                end
            end
            RUN: begin
`ifdef SHA256_SCHED_ABORT_EN
                // Abort wins over a simultaneous handshake; window is left as is.
                if (abort) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else
`endif
                if (w_ready) begin
                    win_next = win_shift;
                    if (idx_reg == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = idx_reg + 6'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
            for (int i = 0; i < 16; i++) begin
                win_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            win_reg   <= win_next;
        end
    end

    // Outputs decode directly from registered state so reset reaches them
    // without waiting for a clock edge.
    assign blk_ready = (state_reg == IDLE);
    assign w_valid   = (state_reg == RUN);
    assign busy      = (state_reg == RUN);
    assign w_data    = win_reg[0];
    assign w_idx     = idx_reg;

endmodule

// File: tb/tb_sha256_msg_schedule.sv
module tb_sha256_msg_schedule;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         w_valid;
    logic         w_ready;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;
    logic         busy;
`ifdef SHA256_SCHED_ABORT_EN
    logic         abort;
`endif

    sha256_msg_schedule #(.WORDS(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_data    (w_data),
        .w_idx     (w_idx),
`ifdef SHA256_SCHED_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference schedule and observed stream
    logic [31:0] exp_w  [64];
    logic [31:0] got_w  [64];
    logic [5:0]  got_idx[64];
    int          n_hs, stab_err, timeout;
    logic        first_valid, end_busy, end_ready, ready_in_run;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule recurrence over a flat 64-entry array.
    task automatic compute_ref(input logic [511:0] b);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = b[511 - 32*t -: 32];
            end else begin
                s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Presents a block and returns one clock after the accepting edge.
    task automatic send_block(input logic [511:0] b, input logic hold);
        int k = 0;
        @(negedge clk);
        while (!blk_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        blk_valid = 1'b1;
        blk_data  = b;
        @(posedge clk);
        #1;
        if (!hold) blk_valid = 1'b0;
    endtask

    // Drives w_ready and records handshaken words until w_valid drops.
    task automatic collect(input int ready_pct);
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic        r;
        logic [31:0] pd = '0;
        logic [5:0]  pi = '0;
        n_hs = 0; stab_err = 0; timeout = 0; ready_in_run = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == 0) first_valid = w_valid;
            cyc++;
            if (cyc > 2000) begin
                timeout = 1;
                w_ready = 1'b0;
                break;
            end
            if (w_valid) begin
                if (blk_ready) ready_in_run = 1'b1;
                if (stalled && (w_data !== pd || w_idx !== pi)) stab_err++;
                r = ($urandom_range(99) < ready_pct);
                w_ready = r;
                if (r) begin
                    if (n_hs < 64) begin
                        got_w[n_hs]   = w_data;
                        got_idx[n_hs] = w_idx;
                    end
                    n_hs++;
                end
                stalled = !r;
                pd = w_data;
                pi = w_idx;
            end else begin
                end_busy  = busy;
                end_ready = blk_ready;
                w_ready   = 1'b0;
                break;
            end
        end
        $display("block streamed: %0d handshakes in %0d cycles, first W=%08h", n_hs, cyc, got_w[0]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; blk_valid = 1'b0; blk_data = '0; w_ready = 1'b0;
`ifdef SHA256_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        #1;
        checks++;
        if (blk_ready !== 1'b1 || w_valid !== 1'b0 || busy !== 1'b0 ||
            w_data !== 32'h0 || w_idx !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs: blk_ready=%b w_valid=%b busy=%b w_data=%08h w_idx=%0d, want 1 0 0 00000000 0",
                     blk_ready, w_valid, busy, w_data, w_idx);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (blk_ready !== 1'b1 || w_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: blk_ready=%b w_valid=%b, want 1 0", blk_ready, w_valid);
        end
    endtask

    task automatic test_abc(input int ready_pct, input string name);
        logic [511:0] b = '0;
        b[511:480] = 32'h61626380;
        b[31:0]    = 32'h00000018;
        compute_ref(b);
        send_block(b, 1'b0);
        collect(ready_pct);
        checks++;
        if (first_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: w_valid=%b one cycle after accept, want 1", name, first_valid);
        end
        checks++;
        if (n_hs != 64 || timeout != 0) begin
            errors++;
            $display("FAIL %s_count: handshakes=%0d timeout=%0d, want 64 0", name, n_hs, timeout);
        end
        checks++;
        if (end_busy !== 1'b0 || end_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_end: busy=%b blk_ready=%b after idx 63, want 0 1", name, end_busy, end_ready);
        end
        checks++;
        if (got_w[16] !== 32'h61626380 || got_w[17] !== 32'h000F0000 || got_w[18] !== 32'h7DA86405) begin
            errors++;
            $display("FAIL %s_w16_18: got %08h %08h %08h, want 61626380 000f0000 7da86405",
                     name, got_w[16], got_w[17], got_w[18]);
        end
        checks++;
        if (stab_err != 0) begin
            errors++;
            $display("FAIL %s_stall_stable: %0d changes while stalled, want 0", name, stab_err);
        end
        for (int i = 0; i < 64 && i < n_hs; i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_idx[i] !== 6'(i)) begin
                errors++;
                $display("FAIL %s_word%0d: W=%08h idx=%0d, want W=%08h idx=%0d",
                         name, i, got_w[i], got_idx[i], exp_w[i], i);
            end
        end
    endtask

    task automatic test_blk_ignored();
        logic [511:0] a = rand_block();
        logic [511:0] b = rand_block();
        compute_ref(a);
        send_block(a, 1'b1);
        blk_data = b;                 // keep blk_valid high with different data
        collect(100);
        checks++;
        if (ready_in_run !== 1'b0 || n_hs != 64) begin
            errors++;
            $display("FAIL held_ignored: blk_ready_seen_in_run=%b handshakes=%0d, want 0 64", ready_in_run, n_hs);
        end
        for (int i = 0; i < 64 && i < n_hs; i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL held_word%0d: W=%08h, want %08h", i, got_w[i], exp_w[i]);
            end
        end
        // collect() stopped on the IDLE cycle; block b is accepted at the next edge.
        @(posedge clk);
        #1;
        blk_valid = 1'b0;
        compute_ref(b);
        collect(70);
        checks++;
        if (first_valid !== 1'b1 || n_hs != 64 || got_w[0] !== exp_w[0] || got_idx[0] !== 6'd0) begin
            errors++;
            $display("FAIL second_block: valid=%b hs=%0d W0=%08h idx=%0d, want 1 64 %08h 0",
                     first_valid, n_hs, got_w[0], got_idx[0], exp_w[0]);
        end
        for (int i = 1; i < 64 && i < n_hs; i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL second_word%0d: W=%08h, want %08h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [511:0] b = rand_block();
        int k = 0;
        send_block(b, 1'b0);
        w_ready = 1'b1;
        @(negedge clk);
        while (w_idx != 6'd20 && k < 100) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (w_idx !== 6'd20 || w_valid !== 1'b1) begin
            errors++;
            $display("FAIL reach_idx20: w_idx=%0d w_valid=%b, want 20 1", w_idx, w_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_idx !== 6'd0 || w_data !== 32'h0) begin
            errors++;
            $display("FAIL async_reset: w_valid=%b blk_ready=%b w_idx=%0d w_data=%08h, want 0 1 0 00000000",
                     w_valid, blk_ready, w_idx, w_data);
        end
        w_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        $display("mid-block reset applied at idx 20");
        b = rand_block();
        compute_ref(b);
        send_block(b, 1'b0);
        collect(80);
        checks++;
        if (n_hs != 64) begin
            errors++;
            $display("FAIL post_reset_count: handshakes=%0d, want 64", n_hs);
        end
        for (int i = 0; i < 64 && i < n_hs; i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_idx[i] !== 6'(i)) begin
                errors++;
                $display("FAIL post_reset_word%0d: W=%08h idx=%0d, want %08h %0d",
                         i, got_w[i], got_idx[i], exp_w[i], i);
            end
        end
    endtask

    task automatic test_all_ones();
        logic [511:0] b = '1;
        compute_ref(b);
        send_block(b, 1'b0);
        collect(100);
        // 0x003FFFFF + 0xFFFFFFFF + 0x1FFFFFFF + 0xFFFFFFFF mod 2^32 = 0x203FFFFC
        checks++;
        if (got_w[16] !== 32'h203FFFFC || n_hs != 64) begin
            errors++;
            $display("FAIL all_ones_w16: W16=%08h hs=%0d, want 203ffffc 64", got_w[16], n_hs);
        end
        for (int i = 0; i < 64 && i < n_hs; i++) begin
            checks++;
            if (got_w[i] !== exp_w[i]) begin
                errors++;
                $display("FAIL all_ones_word%0d: W=%08h, want %08h", i, got_w[i], exp_w[i]);
            end
        end
    endtask

`ifdef SHA256_SCHED_ABORT_EN
    task automatic test_abort();
        logic [511:0] b = rand_block();
        int k = 0;
        send_block(b, 1'b0);
        w_ready = 1'b1;
        @(negedge clk);
        while (w_idx != 6'd10 && k < 100) begin
            @(negedge clk);
            k++;
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        w_ready = 1'b0;
        checks++;
        if (w_valid !== 1'b0 || blk_ready !== 1'b1 || w_idx !== 6'd0) begin
            errors++;
            $display("FAIL abort: w_valid=%b blk_ready=%b w_idx=%0d, want 0 1 0", w_valid, blk_ready, w_idx);
        end
        $display("block aborted at idx 10");
        b = rand_block();
        compute_ref(b);
        send_block(b, 1'b0);
        collect(100);
        for (int i = 0; i < 64 && i < n_hs; i++) begin
            checks++;
            if (got_w[i] !== exp_w[i] || got_idx[i] !== 6'(i)) begin
                errors++;
                $display("FAIL post_abort_word%0d: W=%08h idx=%0d, want %08h %0d",
                         i, got_w[i], got_idx[i], exp_w[i], i);
            end
        end
        checks++;
        if (n_hs != 64) begin
            errors++;
            $display("FAIL post_abort_count: handshakes=%0d, want 64", n_hs);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_abc(100, "abc");
        test_abc(50, "abc_bp");
        test_blk_ignored();
        test_mid_reset();
        test_all_ones();
`ifdef SHA256_SCHED_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
